adc_frame_arbiter: RTL and testbench

Sequences MCP3008-style 10-bit SPI ADC conversion frames and shares the single ADC among N_REQ requesters, such as throttle, phase current and bus voltage, using round-robin arbitration. It sits between the board ADC pins (AD_CLK, CS, DIN, DOUT) and the control logic, replacing ad-hoc frame generation in the control loop. Each grant runs one complete frame on the requested channel and returns the 10-bit result with a one-cycle done strobe.

---
 rtl/adc_pkg.sv | 25 ++
 rtl/spi_adc_frame.sv | 144 ++++++++++++++
 rtl/adc_frame_arbiter.sv | 97 +++++++++
 tb/tb_adc_frame_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and MCP3008 frame constants for the ADC frame arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: frame FSM state enum, command/data bit positions, command word helper.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_GAP
  } state_e;

  localparam int CMD_BITS        = 5;   // start, sgl, d2, d1, d0
  localparam int FIRST_DATA_EDGE = 8;   // rising edge that carries B9
  localparam int LAST_EDGE       = 17;  // rising edge that carries B0
  localparam int RESULT_W        = 10;

  // Command word shifted MSB first on rising edges 1..5.
  function automatic logic [CMD_BITS-1:0] cmd_word(input logic sgl, input logic [2:0] chan);
    return {1'b1, sgl, chan};
  endfunction

endpackage

// File: rtl/spi_adc_frame.sv
// Runs one MCP3008 conversion frame per start pulse and returns the 10-bit result.
// Latency: done_o 1+34*CLK_DIV cycles after the start edge; then CS_GAP cycles of cs_n high.
// Backpressure: start_i is ignored unless busy_o is low.
//
// Ports: clk/rst_n; start_i + chan_i + sgl_i (sampled on the start edge);
//        adc_sclk_o/adc_cs_n_o/adc_din_o/adc_dout_i to the ADC pins;
//        result_o + done_o (one-cycle pulse); busy_o high from start until the gap ends.
module spi_adc_frame
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [2:0]          chan_i,
  input  logic                sgl_i,
  input  logic                adc_dout_i,
  output logic                adc_sclk_o,
  output logic                adc_cs_n_o,
  output logic                adc_din_o,
  output logic [RESULT_W-1:0] result_o,
  output logic                done_o,
  output logic                busy_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_e                state_q;
  logic [DW-1:0]         div_q;
  logic [4:0]            edge_q;      // rising SCLK edges issued so far (0..17)
  logic [GW-1:0]         gap_q;
  logic [CMD_BITS-1:0]   cmd_q;
  logic [RESULT_W-1:0]   shift_q;
  logic [RESULT_W-1:0]   shift_d;
  logic [RESULT_W-1:0]   result_q;
  logic                  sclk_q, cs_n_q, din_q, done_q, busy_q;
  logic                  sync1_q, sync2_q;
  logic                  div_last, gap_last, cap;
  logic [2:0]            nxt_bit;

  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign gap_last = (gap_q == GW'(CS_GAP - 1));
  // Two cycles after a rising edge the synchronised dout reflects the pin as it
  // was at that rising edge, so that is the sample to keep.
  assign cap      = sclk_q && (div_q == DW'(1)) && (edge_q >= 5'(FIRST_DATA_EDGE));
  assign shift_d  = cap ? {shift_q[RESULT_W-2:0], sync2_q} : shift_q;
  // Command bit to present after falling edge k is bit k+1 of the word.
  assign nxt_bit  = 3'(CMD_BITS - 1) - edge_q[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      edge_q   <= '0;
      gap_q    <= '0;
      cmd_q    <= '0;
      shift_q  <= '0;
      result_q <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      sync1_q <= adc_dout_i;
      sync2_q <= sync1_q;
      shift_q <= shift_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_CS_SETUP;
            busy_q  <= 1'b1;
            cmd_q   <= cmd_word(sgl_i, chan_i);
            div_q   <= '0;
            edge_q  <= '0;
          end
        end
        ST_CS_SETUP: begin
          // First cycle drops cs_n and presents the start bit; then CLK_DIV
          // cycles of setup before the first rising edge.
          if (cs_n_q) begin
            cs_n_q <= 1'b0;
            din_q  <= cmd_q[CMD_BITS-1];
          end else if (div_last) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            edge_q  <= 5'd1;
            state_q <= ST_SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!div_last) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              edge_q <= edge_q + 5'd1;
            end else begin
              sclk_q <= 1'b0;
              if (edge_q == 5'(LAST_EDGE)) begin
                cs_n_q   <= 1'b1;
                done_q   <= 1'b1;
                result_q <= shift_d;
                din_q    <= 1'b0;
                gap_q    <= '0;
                state_q  <= ST_CS_GAP;
              end else if (edge_q < 5'(CMD_BITS)) begin
                din_q <= cmd_q[nxt_bit];
              end else begin
                din_q <= 1'b0;
              end
            end
          end
        end
        ST_CS_GAP: begin
          if (gap_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_sclk_o = sclk_q;
  assign adc_cs_n_o = cs_n_q;
  assign adc_din_o  = din_q;
  assign result_o   = result_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/adc_frame_arbiter.sv
// Round-robin shares one MCP3008-style SPI ADC among N_REQ level requesters.
// Latency: done_o pulses 1+34*CLK_DIV cycles after the grant edge; frame period 2+34*CLK_DIV+CS_GAP.
// Backpressure: requests wait (level held) while a frame or CS gap is in progress.
//
// Ports: req_i/chan_i/sgl_i per requester; done_o one-hot pulse to the served requester;
//        result_o last conversion; owner_o current/last grant; busy_o; ADC SPI pins.
module adc_frame_arbiter
  import adc_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*3-1:0]         chan_i,
  input  logic [N_REQ-1:0]           sgl_i,
  output logic [N_REQ-1:0]           done_o,
  output logic [RESULT_W-1:0]        result_o,
  output logic [$clog2(N_REQ)-1:0]   owner_o,
  output logic                       busy_o,
  output logic                       adc_sclk_o,
  output logic                       adc_cs_n_o,
  output logic                       adc_din_o,
  input  logic                       adc_dout_i
);

  localparam int OW = $clog2(N_REQ);

  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] win_idx, idx;
  logic          win_vld;
  logic          start;
  logic          frame_done;
  logic          frame_busy;

  // Search from the pointer upward with wrap; the lowest offset wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = OW'((int'(ptr_q) + i) % N_REQ);
      if (req_i[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign start = win_vld && !frame_busy;

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (start) begin
      owner_d = win_idx;
      ptr_d   = (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  spi_adc_frame #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .chan_i     (chan_i[int'(win_idx)*3 +: 3]),
    .sgl_i      (sgl_i[win_idx]),
    .adc_dout_i (adc_dout_i),
    .adc_sclk_o (adc_sclk_o),
    .adc_cs_n_o (adc_cs_n_o),
    .adc_din_o  (adc_din_o),
    .result_o   (result_o),
    .done_o     (frame_done),
    .busy_o     (frame_busy)
  );

  // Decoded from two registers so the pulse lands on the same edge as result_o.
  assign done_o  = frame_done ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign owner_o = owner_q;
  assign busy_o  = frame_busy;

endmodule

// File: tb/tb_adc_frame_arbiter.sv
module tb_adc_frame_arbiter;

  localparam int N        = 3;
  localparam int CD       = 4;
  localparam int GAP      = 8;
  localparam int DONE_LAT = 1 + 34 * CD;        // grant edge to done edge
  localparam int PERIOD   = 2 + 34 * CD + GAP;  // back-to-back frame spacing

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [3*N-1:0] chan_i = '0;
  logic [N-1:0]   sgl_i = '0;
  logic [N-1:0]   done_o;
  logic [9:0]     result_o;
  logic [1:0]     owner_o;
  logic           busy_o, adc_sclk_o, adc_cs_n_o, adc_din_o;
  logic           adc_dout_i = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_frame_arbiter #(.N_REQ(N), .CLK_DIV(CD), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .chan_i(chan_i), .sgl_i(sgl_i),
    .done_o(done_o), .result_o(result_o), .owner_o(owner_o), .busy_o(busy_o),
    .adc_sclk_o(adc_sclk_o), .adc_cs_n_o(adc_cs_n_o), .adc_din_o(adc_din_o),
    .adc_dout_i(adc_dout_i)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- ADC contents and reference model ----------------
  logic [9:0] adc_mem [16];

  typedef struct {
    int owner;
    int value;
    int done_cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mdl_e, mon_e;
  int   cyc = 0;
  int   rr_ptr = 0;
  int   next_free = 0;
  int   mdl_w;
  bit   granted [N];
  int   done_cnt = 0;

  // Transaction-level model: a grant is possible once the previous frame's
  // period has elapsed; winner is the first requester at or after the pointer.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      expq.delete();
      rr_ptr = 0;
      next_free = 0;
      for (int i = 0; i < N; i++) granted[i] = 1'b0;
    end else if (cyc >= next_free && req_i != '0) begin
      mdl_w = -1;
      for (int i = 0; i < N; i++)
        if (mdl_w < 0 && req_i[(rr_ptr + i) % N]) mdl_w = (rr_ptr + i) % N;
      mdl_e.owner    = mdl_w;
      mdl_e.value    = int'(adc_mem[{sgl_i[mdl_w], chan_i[3*mdl_w +: 3]}]);
      mdl_e.done_cyc = cyc + DONE_LAT;
      expq.push_back(mdl_e);
      rr_ptr    = (mdl_w + 1) % N;
      next_free = cyc + PERIOD;
      granted[mdl_w] = 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done_o != '0) begin
      if (expq.size() == 0) begin
        check("unexpected_done", int'(done_o), 0);
      end else begin
        mon_e = expq.pop_front();
        check("done_onehot", int'(done_o), 1 << mon_e.owner);
        check("result", int'(result_o), mon_e.value);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("owner", int'(owner_o), mon_e.owner);
        granted[mon_e.owner] = 1'b0;
        done_cnt++;
      end
    end
  end

  // ---------------- ADC pin model and SPI timing checker ----------------
  bit         sclk_p = 1'b0, din_p = 1'b0, cs_p = 1'b1;
  int         rcnt = 0, fcnt = 0, hi_cnt = 100;
  logic [4:0] cmd = '0;
  logic [4:0] last_cmd = '0;
  logic [9:0] aval = '0;

  always @(negedge clk) begin
    if (adc_cs_n_o) begin
      check("sclk_idle_low", int'(adc_sclk_o), 0);
      check("din_idle_low", int'(adc_din_o), 0);
      rcnt = 0;
      fcnt = 0;
      adc_dout_i = 1'b0;
      hi_cnt++;
    end else begin
      if (cs_p) begin
        check("cs_gap_min", int'(hi_cnt >= GAP), 1);
        hi_cnt = 0;
      end
      if (adc_din_o != din_p) check("din_change_sclk_low", int'(adc_sclk_o), 0);
      if (adc_sclk_o && !sclk_p) begin
        rcnt++;
        if (rcnt <= 5) cmd[5 - rcnt] = adc_din_o;
        else check("din_zero_after_cmd", int'(adc_din_o), 0);
        if (rcnt == 5) begin
          check("start_bit", int'(cmd[4]), 1);
          last_cmd = cmd;
          aval = adc_mem[{cmd[3], cmd[2:0]}];
        end
      end
      if (!adc_sclk_o && sclk_p) begin
        fcnt++;
        // Data bit for rising edge k+1 is driven after falling edge k.
        if (fcnt >= 7 && fcnt <= 16) adc_dout_i = aval[16 - fcnt];
        else adc_dout_i = 1'b0;
      end
    end
    sclk_p = adc_sclk_o;
    din_p  = adc_din_o;
    cs_p   = adc_cs_n_o;
  end

  // ---------------- Stimulus ----------------
  bit auto_drop = 1'b1;

  task automatic tick();
    @(negedge clk);
    if (auto_drop) req_i = req_i & ~done_o;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((req_i != '0 || expq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (req_i != '0 || expq.size() != 0)
      check(nm, expq.size() + int'(req_i != '0), 0);
  endtask

  task automatic set_req(input int i, input int ch, input bit sg);
    chan_i[3*i +: 3] = 3'(ch);
    sgl_i[i] = sg;
    req_i[i] = 1'b1;
  endtask

  int exp_own [4] = '{0, 1, 2, 0};
  int k, n, prev, rises, target;
  bit bprev, sprev;

  initial begin
    for (int i = 0; i < 16; i++) adc_mem[i] = 10'($urandom_range(0, 1023));
    adc_mem[{1'b1, 3'd5}] = 10'h2A5;

    // Reset state.
    repeat (5) @(negedge clk);
    check("rst_cs_n", int'(adc_cs_n_o), 1);
    check("rst_sclk", int'(adc_sclk_o), 0);
    check("rst_din", int'(adc_din_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_result", int'(result_o), 0);
    check("rst_owner", int'(owner_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // All requesters held high: grants 0,1,2,0, each done PERIOD apart.
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    auto_drop = 1'b0;
    k = 0; n = 0; prev = 0;
    while (k < 4 && n < 1000) begin
      tick();
      n++;
      if (done_o != '0) begin
        check("rr_order", int'(owner_o), exp_own[k]);
        if (k > 0) check("rr_period", cyc - prev, PERIOD);
        prev = cyc;
        k++;
        if (k == 4) req_i = '0;
      end
    end
    if (k < 4) check("rr_timeout", k, 4);
    auto_drop = 1'b1;
    drain("rr_drain", 400);

    // Pointer continuity: serve 1, then 0 must precede 1.
    set_req(1, 2, 1'b0);
    drain("ptr_first", 400);
    set_req(0, 7, 1'b1);
    set_req(1, 4, 1'b1);
    n = 0;
    while (done_o == '0 && n < 400) begin
      tick();
      n++;
    end
    check("ptr_first_owner", int'(owner_o), 0);
    tick();
    drain("ptr_drain", 400);

    // Single request: requester 0, channel 5, single-ended, ADC returns 0x2A5.
    set_req(0, 5, 1'b1);
    drain("single", 400);
    check("single_cmd_bits", int'(last_cmd), 5'b11101);
    check("single_result", int'(result_o), 10'h2A5);

    // Requester 2 drops at cycle 40 of its frame: still served, no re-grant.
    set_req(2, 3, 1'b0);
    n = 0; bprev = busy_o;
    while (!(busy_o && !bprev) && n < 400) begin
      bprev = busy_o;
      tick();
      n++;
    end
    check("drop_grant_seen", int'(busy_o), 1);
    repeat (40) tick();
    req_i[2] = 1'b0;
    n = 0;
    while (done_o == '0 && n < 200) begin
      tick();
      n++;
    end
    check("drop_done", int'(done_o), 3'b100);
    rises = 0; bprev = busy_o;
    repeat (300) begin
      tick();
      if (busy_o && !bprev) rises++;
      bprev = busy_o;
    end
    check("drop_no_regrant", rises, 0);

    // Reset at rising SCLK edge 9 of a frame.
    set_req(2, 6, 1'b1);
    k = 0; n = 0; sprev = adc_sclk_o;
    while (k < 9 && n < 600) begin
      tick();
      n++;
      if (adc_sclk_o && !sprev) k++;
      sprev = adc_sclk_o;
    end
    check("mid_reset_edge9", k, 9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", int'(adc_cs_n_o), 1);
    check("mid_rst_sclk", int'(adc_sclk_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_done", int'(done_o), 0);
    check("mid_rst_result", int'(result_o), 0);
    check("mid_rst_owner", int'(owner_o), 0);
    req_i = '0;
    repeat (12) tick();
    rst_n = 1'b1;
    set_req(1, 1, 1'b1);
    drain("post_reset", 400);

    // Random traffic.
    target = done_cnt + 250;
    n = 0;
    while (done_cnt < target && n < 60000) begin
      tick();
      n++;
      for (int i = 0; i < N; i++) begin
        if (!req_i[i]) begin
          if (!granted[i] && !done_o[i] && $urandom_range(0, 7) == 0)
            set_req(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end else if (!granted[i]) begin
          if ($urandom_range(0, 63) == 0) req_i[i] = 1'b0;
        end else if ($urandom_range(0, 199) == 0) begin
          req_i[i] = 1'b0;
        end
      end
    end
    check("random_frames", int'(done_cnt >= target), 1);
    for (int i = 0; i < N; i++) if (!granted[i]) req_i[i] = 1'b0;
    drain("random_drain", 1000);
    repeat (20) tick();
    check("queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
